// File: rtl/uart_wb_master.sv
// UART-to-Wishbone bridge: 'W' adr d3 d2 d1 d0 writes a word, 'R' adr reads one,
// with single-byte status or 4-byte data responses sent back over the same UART.
module uart_wb_master #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT      = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [7:0]  adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  output logic        busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    P_IDLE, P_ADDR, P_DATA0, P_DATA1, P_DATA2, P_DATA3, P_BUS, P_RESP
  } pstate_t;

  logic          rx_meta_r, rx_sync_r, rx_prev_r, rx_act_r, rx_valid_r, rx_ferr_r;
  logic [CW-1:0] rx_cnt_r;
  logic [3:0]    rx_bit_r;
  logic [7:0]    rx_shift_r;

  logic          tx_act_r, tx_done_s, tx_start_s;
  logic [CW-1:0] tx_cnt_r;
  logic [3:0]    tx_bit_r;
  logic [9:0]    tx_shift_r;

  pstate_t       state_r, state_s;
  logic          write_r, write_s, cyc_s, stb_s, we_s, busy_s;
  logic [7:0]    adr_s;
  logic [31:0]   dat_s, buf_r, buf_s;
  logic [2:0]    left_r, left_s;
  logic [TW-1:0] tmo_r, tmo_s;

  // Receiver: synchronizer, start-bit qualification at half a bit, mid-bit sampling
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta_r  <= 1'b1;
      rx_sync_r  <= 1'b1;
      rx_prev_r  <= 1'b1;
      rx_act_r   <= 1'b0;
      rx_valid_r <= 1'b0;
      rx_ferr_r  <= 1'b0;
      rx_cnt_r   <= '0;
      rx_bit_r   <= 4'd0;
      rx_shift_r <= 8'h00;
    end else begin
      rx_meta_r  <= rx_i;
      rx_sync_r  <= rx_meta_r;
      rx_prev_r  <= rx_sync_r;
      rx_valid_r <= 1'b0;
      rx_ferr_r  <= 1'b0;
      if (!rx_act_r) begin
        if (rx_prev_r && !rx_sync_r) begin
          rx_act_r <= 1'b1;
          rx_cnt_r <= '0;
          rx_bit_r <= 4'd0;
        end
      end else if (rx_bit_r == 4'd0) begin
        if (rx_cnt_r == HALF_END) begin
          rx_cnt_r <= '0;
          if (!rx_sync_r) rx_bit_r <= 4'd1;
          else            rx_act_r <= 1'b0;
        end else begin
          rx_cnt_r <= rx_cnt_r + CW'(1);
        end
      end else if (rx_cnt_r == BIT_END) begin
        rx_cnt_r <= '0;
        if (rx_bit_r == 4'd9) begin
          rx_act_r   <= 1'b0;
          rx_valid_r <= rx_sync_r;
          rx_ferr_r  <= !rx_sync_r;
        end else begin
          rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
          rx_bit_r   <= rx_bit_r + 4'd1;
        end
      end else begin
        rx_cnt_r <= rx_cnt_r + CW'(1);
      end
    end
  end

  assign tx_done_s = tx_act_r && (tx_cnt_r == BIT_END) && (tx_bit_r == 4'd9);

  // Parser next-state: command decode, bus cycle with timeout, response sequencing
  always_comb begin
    state_s    = state_r;
    write_s    = write_r;
    adr_s      = adr_o;
    dat_s      = dat_o;
    cyc_s      = cyc_o;
    stb_s      = stb_o;
    we_s       = we_o;
    tmo_s      = tmo_r;
    buf_s      = buf_r;
    left_s     = left_r;
    tx_start_s = 1'b0;
    case (state_r)
      P_IDLE: begin
        if (rx_valid_r) begin
          if (rx_shift_r == 8'h57) begin
            write_s = 1'b1;
            state_s = P_ADDR;
          end else if (rx_shift_r == 8'h52) begin
            write_s = 1'b0;
            state_s = P_ADDR;
          end else begin
            buf_s   = {8'h3F, 24'h000000};
            left_s  = 3'd1;
            state_s = P_RESP;
          end
        end else begin
          state_s = P_IDLE;
        end
      end
      P_ADDR, P_DATA0, P_DATA1, P_DATA2, P_DATA3: begin
        if (rx_valid_r) begin
          case (state_r)
            P_ADDR: begin
              adr_s   = rx_shift_r;
              state_s = write_r ? P_DATA0 : P_BUS;
            end
            P_DATA0: begin dat_s[31:24] = rx_shift_r; state_s = P_DATA1; end
            P_DATA1: begin dat_s[23:16] = rx_shift_r; state_s = P_DATA2; end
            P_DATA2: begin dat_s[15:8]  = rx_shift_r; state_s = P_DATA3; end
            P_DATA3: begin dat_s[7:0]   = rx_shift_r; state_s = P_BUS;   end
            default: state_s = P_IDLE;
          endcase
        end else if (rx_ferr_r) begin
          state_s = P_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      P_BUS: begin
        if (!cyc_o) begin
          cyc_s = 1'b1;
          stb_s = 1'b1;
          we_s  = write_r;
          tmo_s = '0;
        end else if (ack_i) begin
          cyc_s   = 1'b0;
          stb_s   = 1'b0;
          we_s    = 1'b0;
          state_s = P_RESP;
          if (write_r) begin
            buf_s  = {8'h4B, 24'h000000};
            left_s = 3'd1;
          end else begin
            buf_s  = dat_i;
            left_s = 3'd4;
          end
        end else if (tmo_r == TMO_END) begin
          cyc_s   = 1'b0;
          stb_s   = 1'b0;
          we_s    = 1'b0;
          buf_s   = {8'h45, 24'h000000};
          left_s  = 3'd1;
          state_s = P_RESP;
        end else begin
          tmo_s = tmo_r + TW'(1);
        end
      end
      P_RESP: begin
        // Next byte loads on the same edge the previous stop bit ends: no idle gap
        if (tx_done_s && (left_r == 3'd0)) begin
          state_s = P_IDLE;
        end else if ((!tx_act_r || tx_done_s) && (left_r != 3'd0)) begin
          tx_start_s = 1'b1;
          buf_s      = {buf_r[23:0], 8'h00};
          left_s     = left_r - 3'd1;
        end else begin
          state_s = P_RESP;
        end
      end
      default: state_s = P_IDLE;
    endcase
    busy_s = (state_s != P_IDLE);
  end

  // Parser and Wishbone output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= P_IDLE;
      write_r <= 1'b0;
      adr_o   <= 8'h00;
      dat_o   <= 32'h00000000;
      cyc_o   <= 1'b0;
      stb_o   <= 1'b0;
      we_o    <= 1'b0;
      tmo_r   <= '0;
      buf_r   <= 32'h00000000;
      left_r  <= 3'd0;
      busy_o  <= 1'b0;
    end else begin
      state_r <= state_s;
      write_r <= write_s;
      adr_o   <= adr_s;
      dat_o   <= dat_s;
      cyc_o   <= cyc_s;
      stb_o   <= stb_s;
      we_o    <= we_s;
      tmo_r   <= tmo_s;
      buf_r   <= buf_s;
      left_r  <= left_s;
      busy_o  <= busy_s;
    end
  end

  // Transmitter: 10-bit frame shifter, line idles high from the shifted-in ones
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_act_r   <= 1'b0;
      tx_cnt_r   <= '0;
      tx_bit_r   <= 4'd0;
      tx_shift_r <= 10'h3FF;
    end else if (tx_start_s) begin
      tx_act_r   <= 1'b1;
      tx_cnt_r   <= '0;
      tx_bit_r   <= 4'd0;
      tx_shift_r <= {1'b1, buf_r[31:24], 1'b0};
    end else if (tx_act_r) begin
      if (tx_cnt_r == BIT_END) begin
        tx_cnt_r   <= '0;
        tx_shift_r <= {1'b1, tx_shift_r[9:1]};
        if (tx_bit_r == 4'd9) tx_act_r <= 1'b0;
        else                  tx_bit_r <= tx_bit_r + 4'd1;
      end else begin
        tx_cnt_r <= tx_cnt_r + CW'(1);
      end
    end
  end

  assign tx_o = tx_shift_r[0];

endmodule

// File: tb/tb_uart_wb_master.sv
// Bench for uart_wb_master: directed vector table, random commands against a
// command-level model, plus framing, overlap and reset sequences.
module tb_uart_wb_master;
  localparam int CPB = 8;
  localparam int TMO = 300;

  logic clk = 1'b0, rst_n = 1'b0, rx_i = 1'b1, ack_i, tx_o, cyc_o, stb_o, we_o, busy_o;
  logic [7:0]  adr_o;
  logic [31:0] dat_o, dat_i;

  uart_wb_master #(.CLKS_PER_BIT(CPB), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .rx_i(rx_i), .tx_o(tx_o), .cyc_o(cyc_o),
    .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i),
    .ack_i(ack_i), .busy_o(busy_o));

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    int nb; logic [47:0] cmd; bit ack_en; int dly; logic [31:0] rd;
    int nx; logic [23:0] ext; bit spur;
    int ntx; bit we; logic [7:0] adr; logic [31:0] dat; int nr; logic [31:0] resp;
  } vec_t;

  int n_cmp = 0, n_err = 0;

  // slave configuration (main) and observations (slave/monitor)
  bit ack_en_cfg = 1'b1;
  int dly_cfg = 0, spur_n = 0, spur_done = 0, viol = 0, last_rise = 0, last_fall = 0;
  logic [31:0] rd_cfg = 32'h0;
  logic [7:0]  txa_q[$];
  logic [31:0] txd_q[$];
  bit          txw_q[$];
  logic [7:0]  mb_q[$];
  int          mt_q[$];
  bit          ms_q[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Wishbone slave model: acks after dly_cfg cycles, records cycles, checks stability
  initial begin : slave
    bit in_cyc; int wcnt; logic [40:0] saved;
    in_cyc = 1'b0; wcnt = 0; saved = '0;
    ack_i = 1'b0; dat_i = 32'h0;
    forever begin
      @(negedge clk);
      if (ack_i) begin ack_i = 1'b0; dat_i = ~rd_cfg; end
      if (spur_n != spur_done) begin
        spur_done = spur_n;
        if (!cyc_o) begin ack_i = 1'b1; dat_i = 32'h5A5A5A5A; end
      end
      if (stb_o && !cyc_o) viol++;
      if (cyc_o && stb_o) begin
        if (!in_cyc) begin
          in_cyc = 1'b1; wcnt = 0; last_rise = cyc_cnt;
          saved = {we_o, adr_o, dat_o};
          txw_q.push_back(we_o); txa_q.push_back(adr_o); txd_q.push_back(dat_o);
        end else if ({we_o, adr_o, dat_o} !== saved) begin
          viol++;
        end
        if (ack_en_cfg && wcnt == dly_cfg) begin ack_i = 1'b1; dat_i = rd_cfg; end
        wcnt++;
      end else if (in_cyc && !cyc_o) begin
        in_cyc = 1'b0; last_fall = cyc_cnt;
      end
    end
  end

  // UART receive monitor on tx_o, sampling mid-bit
  initial begin : mon
    logic [7:0] b; int t0;
    forever begin
      @(negedge clk);
      if (tx_o === 1'b0) begin
        t0 = cyc_cnt;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx_o;
        end
        repeat (CPB) @(negedge clk);
        mb_q.push_back(b); mt_q.push_back(t0); ms_q.push_back(tx_o);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = stop_ok;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
  endtask

  task automatic wait_idle(output bit ok, output int tf);
    ok = 1'b0; tf = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!busy_o) begin ok = 1'b1; tf = cyc_cnt; break; end
    end
  endtask

  task automatic chk_reset(input string nm);
    chk(nm, {tx_o, cyc_o, stb_o, we_o, adr_o, dat_o, busy_o}, {1'b1, 44'h0});
  endtask

  function automatic vec_t mk(int nb, logic [47:0] cmd, bit ack_en, int dly, logic [31:0] rd,
                              int nx, logic [23:0] ext, bit spur, int ntx, bit we,
                              logic [7:0] adr, logic [31:0] dat, int nr, logic [31:0] resp);
    vec_t v;
    v.nb = nb; v.cmd = cmd; v.ack_en = ack_en; v.dly = dly; v.rd = rd;
    v.nx = nx; v.ext = ext; v.spur = spur; v.ntx = ntx; v.we = we;
    v.adr = adr; v.dat = dat; v.nr = nr; v.resp = resp;
    return v;
  endfunction

  // Command-level reference: what the bridge should do for one command
  function automatic vec_t model(int nb, logic [47:0] cmd, bit ack_en, int dly, logic [31:0] rd);
    vec_t v;
    v = mk(nb, cmd, ack_en, dly, rd, 0, 24'h0, 1'b0, 0, 1'b0, 8'h0, 32'h0, 1, 32'h3F000000);
    if (cmd[47:40] == 8'h57 || cmd[47:40] == 8'h52) begin
      v.ntx = 1; v.we = (cmd[47:40] == 8'h57); v.adr = cmd[39:32]; v.dat = cmd[31:0];
      if (!ack_en)   v.resp = 32'h45000000;
      else if (v.we) v.resp = 32'h4B000000;
      else begin v.nr = 4; v.resp = rd; end
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int tb0, mb0, tf, nresp; bit ok;
    tb0 = txa_q.size(); mb0 = mb_q.size();
    ack_en_cfg = v.ack_en; dly_cfg = v.dly; rd_cfg = v.rd;
    for (int i = 0; i < v.nb; i++) begin
      send_byte(v.cmd[47-8*i -: 8], 1'b1);
      if (i == 0) begin
        repeat (CPB / 2) @(negedge clk);
        chk({nm, " busy"}, busy_o, 1);
        if (v.spur) begin
          spur_n++;
          repeat (3) @(negedge clk);
          chk({nm, " spur"}, {cyc_o, stb_o}, 0);
        end
      end
    end
    for (int i = 0; i < v.nx; i++) send_byte(v.ext[23-8*i -: 8], 1'b1);
    wait_idle(ok, tf);
    chk({nm, " idle"}, ok, 1);
    repeat (CPB) @(negedge clk);
    chk({nm, " ntx"}, txa_q.size() - tb0, v.ntx);
    if (v.ntx == 1 && txa_q.size() > tb0) begin
      chk({nm, " we"}, txw_q[tb0], v.we);
      chk({nm, " adr"}, txa_q[tb0], v.adr);
      if (v.we) chk({nm, " dat"}, txd_q[tb0], v.dat);
      if (!v.ack_en) chk({nm, " tmo"}, last_fall - last_rise, TMO);
    end
    nresp = mb_q.size() - mb0;
    chk({nm, " nresp"}, nresp, v.nr);
    for (int i = 0; i < v.nr && i < nresp; i++) begin
      chk($sformatf("%s resp%0d", nm, i), mb_q[mb0+i], v.resp[31-8*i -: 8]);
      chk($sformatf("%s stop%0d", nm, i), ms_q[mb0+i], 1);
      if (i > 0) chk($sformatf("%s gap%0d", nm, i), mt_q[mb0+i] - mt_q[mb0+i-1], 10 * CPB);
    end
    if (nresp > 0) chk({nm, " busyfall"}, tf - mt_q[mb_q.size()-1], 10 * CPB);
  endtask

  initial begin : main
    vec_t tbl[7];
    vec_t v;
    int k, low, nb, mb0;
    logic [7:0] b; logic [31:0] rd;
    bit ok;

    tbl[0] = mk(6, 48'h5710DEADBEEF, 1, 3,   32'h0,        0, 24'h0,     0, 1, 1, 8'h10, 32'hDEADBEEF, 1, 32'h4B000000);
    tbl[1] = mk(2, 48'h520400000000, 1, 1,   32'h12345678, 0, 24'h0,     0, 1, 0, 8'h04, 32'h0,        4, 32'h12345678);
    tbl[2] = mk(2, 48'h520800000000, 0, 0,   32'h0,        0, 24'h0,     0, 1, 0, 8'h08, 32'h0,        1, 32'h45000000);
    tbl[3] = mk(1, 48'h410000000000, 1, 0,   32'h0,        0, 24'h0,     0, 0, 0, 8'h00, 32'h0,        1, 32'h3F000000);
    tbl[4] = mk(2, 48'h523000000000, 1, 120, 32'hCAFEF00D, 3, 24'h574152, 0, 1, 0, 8'h30, 32'h0,       4, 32'hCAFEF00D);
    tbl[5] = mk(6, 48'h57FF00000001, 1, 0,   32'h0,        0, 24'h0,     0, 1, 1, 8'hFF, 32'h00000001, 1, 32'h4B000000);
    tbl[6] = mk(6, 48'h5722A5A5A5A5, 1, 5,   32'h0,        0, 24'h0,     1, 1, 1, 8'h22, 32'hA5A5A5A5, 1, 32'h4B000000);

    repeat (3) @(negedge clk);
    chk_reset("reset_state");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // framing error on 'W' must be dropped; the following read runs alone
    send_byte(8'h57, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    chk("ferr busy", busy_o, 0);
    run_vec(mk(2, 48'h520000000000, 1, 2, 32'h0BADF00D, 0, 24'h0, 0, 1, 0, 8'h00, 32'h0, 4, 32'h0BADF00D), "ferr_read");

    for (int i = 0; i < 8; i++) begin
      k  = $urandom_range(0, 2);
      rd = $urandom;
      b  = 8'($urandom);
      if (k == 0)      begin nb = 6; v = model(nb, {8'h57, b, rd ^ 32'h3C3C0F0F}, ($urandom_range(0, 3) != 0), $urandom_range(0, 10), rd); end
      else if (k == 1) begin nb = 2; v = model(nb, {8'h52, b, 32'h0}, ($urandom_range(0, 3) != 0), $urandom_range(0, 10), rd); end
      else begin
        if (b == 8'h57 || b == 8'h52) b = 8'h00;
        nb = 1; v = model(nb, {b, 40'h0}, 1'b1, 0, rd);
      end
      run_vec(v, $sformatf("rnd%0d", i));
    end

    // reset while collecting the third data byte
    ack_en_cfg = 1'b1; dly_cfg = 1;
    send_byte(8'h57, 1'b1); send_byte(8'h40, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst1 pre", {busy_o, adr_o, dat_o[31:16]}, {1'b1, 8'h40, 16'h0102});
    rst_n = 1'b0;
    #1;
    chk_reset("rst1 outputs");
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (CPB) @(negedge clk);
    run_vec(mk(6, 48'h573355667788, 1, 2, 32'h0, 0, 24'h0, 0, 1, 1, 8'h33, 32'h55667788, 1, 32'h4B000000), "rst1_after");

    // reset during the second byte of a read response
    mb0 = mb_q.size(); rd_cfg = 32'h89ABCDEF; dly_cfg = 2;
    send_byte(8'h52, 1'b1); send_byte(8'h44, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (mb_q.size() > mb0) begin ok = 1'b1; break; end
    end
    chk("rst2 first byte", ok, 1);
    repeat (2 * CPB) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("rst2 outputs");
    low = 0;
    repeat (12 * CPB) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || cyc_o !== 1'b0) low++;
    end
    chk("rst2 quiet", low, 0);
    rst_n = 1'b1;
    repeat (CPB) @(negedge clk);
    run_vec(mk(6, 48'h5799CAFEBABE, 1, 4, 32'h0, 0, 24'h0, 0, 1, 1, 8'h99, 32'hCAFEBABE, 1, 32'h4B000000), "rst2_after");

    chk("wb stability", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_wb_master.md
UART_WB_MASTER -- requirements
Module: uart_wb_master

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk_i cycles per UART bit, 8N1 framing; minimum 4.
REQ-002 Parameter TIMEOUT, default 1024: clk_i cycles to wait for ack_i before aborting a bus cycle.
REQ-003 Port clk_i  input  1  single clock for all logic.
REQ-004 Port rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 Port rx_i  input  1  UART serial input, idle high, asynchronous to clk_i.
REQ-006 Port tx_o  output  1  UART serial output, idle high.
REQ-007 Port cyc_o, stb_o, we_o  output  1 each  Wishbone master cycle, strobe and write-enable.
REQ-008 Port adr_o  output  8  Wishbone byte address.
REQ-009 Port dat_o  output  32  Wishbone write data.
REQ-010 Port dat_i  input  32  Wishbone read data.
REQ-011 Port ack_i  input  1  Wishbone slave acknowledge.
REQ-012 Port busy_o  output  1  high from the first command byte until the response's last stop bit completes.

Function
REQ-013 rx_i SHALL pass through a 2-flop synchronizer; a start bit is a high-to-low edge, confirmed low at CLKS_PER_BIT/2, then each of 8 data bits (LSB first) and the stop bit SHALL be sampled at the middle of its bit period.
REQ-014 A stop bit sampled low SHALL be a framing error: the byte is discarded and the command parser returns to IDLE.
REQ-015 Parser states: IDLE, ADDR, DATA0..DATA3, BUS, RESP.
REQ-016 IDLE: 0x57 ('W') -> ADDR with write flag; 0x52 ('R') -> ADDR with read flag; any other byte -> RESP sending single byte 0x3F ('?').
REQ-017 ADDR: byte latched into adr_o; a write -> DATA0, a read -> BUS.
REQ-018 DATA0..DATA3: bytes latched into dat_o[31:24], [23:16], [15:8], [7:0] in order; after DATA3 -> BUS.
REQ-019 BUS entry: cyc_o, stb_o high on the next clk_i edge; we_o = write flag; all held stable until ack_i or timeout.
REQ-020 ack_i sampled high while stb_o high SHALL deassert cyc_o, stb_o, we_o on the next edge; a read SHALL capture dat_i on the ack_i edge.
REQ-021 ack_i while cyc_o is low SHALL be ignored.
REQ-022 No ack_i within TIMEOUT cycles of stb_o rising: deassert cyc_o, stb_o, we_o and respond single byte 0x45 ('E').
REQ-023 Write acked -> respond single byte 0x4B ('K'); read acked -> respond 4 bytes of captured data, MSB first.
REQ-024 Transmitter: start bit, 8 data bits LSB first, stop bit, each exactly CLKS_PER_BIT cycles; response bytes back-to-back with no idle gap.
REQ-025 Bytes received while in BUS or RESP SHALL be discarded and SHALL NOT alter state; receiver keeps framing so the next command is decoded correctly.
REQ-026 After the last response stop bit the parser SHALL return to IDLE and busy_o SHALL fall the same cycle.
REQ-027 At most one Wishbone cycle outstanding; stb_o never asserted without cyc_o.

Reset
REQ-028 rst_n_i low SHALL immediately force tx_o=1, cyc_o=0, stb_o=0, we_o=0, adr_o=0, dat_o=0, busy_o=0, parser IDLE, receiver and transmitter idle, bit and timeout counters 0.
REQ-029 Reset mid-bus-cycle or mid-transmission SHALL abort it with no further ack_i capture or tx_o activity; operation resumes on the first start bit after rst_n_i rises.

Verification
REQ-030 Write: send 57 10 DE AD BE EF, slave acks after 3 cycles -> one cycle with adr_o=0x10, dat_o=0xDEADBEEF, we_o=1; tx_o returns 0x4B.
REQ-031 Read: send 52 04, slave returns 0x12345678 with ack -> we_o=0; tx_o returns 12 34 56 78 back-to-back.
REQ-032 Timeout: send 52 08, ack_i never asserted -> cyc_o drops exactly TIMEOUT cycles after stb_o rose; tx_o returns 0x45.
REQ-033 Bad command/framing: send 0x41 -> 0x3F returned; send 57 with stop bit low, then valid 52 00 -> only the read executes.
REQ-034 Overlap: send extra bytes during BUS and RESP -> ignored; the next full command after busy_o falls executes correctly.
REQ-035 Reset: assert rst_n_i during DATA2 and during response byte 2 -> all outputs at reset values within one cycle; a subsequent write completes normally.
